// File: rtl/rf_ctrl_pkg.sv
// Shared encodings for the register-file access controller.
//   RW_*      : register-file command (read/write)
//   RSEL_HOLD : read-route code that leaves read0/read1 unchanged
//   WSEL_*    : write target select
//   state_t   : read sequencer state
package rf_ctrl_pkg;

  localparam logic       RW_READ   = 1'b0;
  localparam logic       RW_WRITE  = 1'b1;
  localparam logic [1:0] RSEL_HOLD = 2'b01;
  localparam logic       WSEL_A    = 1'b0;
  localparam logic       WSEL_B    = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/rf_grant_logic.sv
// Combinational arbiter between the WB write requester and the ID read
// requester. WB has priority until it has won MAX_WB_STREAK consecutive
// grants while an ID read is waiting; then ID wins once.
//   wb_req, id_req : requests
//   state          : read sequencer state (ID only grantable in IDLE)
//   streak         : current WB win streak
//   id_ack, wb_ack : grants (at most one asserted)
//   streak_nxt     : streak value for the next cycle
module rf_grant_logic
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WB_STREAK = 3,
  parameter int unsigned SW            = 2
) (
  input  logic          wb_req,
  input  logic          id_req,
  input  state_t        state,
  input  logic [SW-1:0] streak,
  output logic          id_ack,
  output logic          wb_ack,
  output logic [SW-1:0] streak_nxt
);

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_WB_STREAK);

  logic id_ok;
  logic read_wins;

  always_comb begin
    id_ok     = id_req & (state == IDLE);
    read_wins = id_ok & (~wb_req | (streak == STREAK_MAX));
    id_ack    = read_wins;
    wb_ack    = wb_req & ~read_wins;

    // Streak only grows while ID is actually waiting behind WB.
    streak_nxt = streak;
    if (read_wins || !id_req) begin
      streak_nxt = '0;
    end else if (wb_ack && streak != STREAK_MAX) begin
      streak_nxt = streak + SW'(1);
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequencer/arbiter in front of the two-entry register file's single
// command port. Issues WB writes and ID reads, drives the hold command
// when idle, and returns read data two edges after the read grant.
//   sysclk, sysrst_n       : clock, async active-low reset
//   wb_req/sel/data/ack    : WB write requester
//   id_req/rsel/ack        : ID read requester
//   id_rdata0/1, id_rvalid : captured read data and its valid pulse
//   rf_rw/wsel/rsel/w      : registered register-file command
//   rf_read0/1             : register-file read outputs
module regfile_access_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned MAX_WB_STREAK = 3
) (
  input  logic             sysclk,
  input  logic             sysrst_n,
  input  logic             wb_req,
  input  logic             wb_sel,
  input  logic [WIDTH-1:0] wb_data,
  output logic             wb_ack,
  input  logic             id_req,
  input  logic [1:0]       id_rsel,
  output logic             id_ack,
  output logic [WIDTH-1:0] id_rdata0,
  output logic [WIDTH-1:0] id_rdata1,
  output logic             id_rvalid,
  output logic             rf_rw,
  output logic             rf_wsel,
  output logic [1:0]       rf_rsel,
  output logic [WIDTH-1:0] rf_w,
  input  logic [WIDTH-1:0] rf_read0,
  input  logic [WIDTH-1:0] rf_read1
);

  localparam int unsigned SW = (MAX_WB_STREAK < 2) ? 1 : $clog2(MAX_WB_STREAK + 1);

  state_t        state;
  logic [SW-1:0] streak;
  logic [SW-1:0] streak_nxt;
  logic          rd_issued;   // read command on the port this cycle
  logic          rd_landed;   // register file has updated read0/read1

  rf_grant_logic #(
    .MAX_WB_STREAK (MAX_WB_STREAK),
    .SW            (SW)
  ) u_grant (
    .wb_req     (wb_req),
    .id_req     (id_req),
    .state      (state),
    .streak     (streak),
    .id_ack     (id_ack),
    .wb_ack     (wb_ack),
    .streak_nxt (streak_nxt)
  );

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state     <= IDLE;
      streak    <= '0;
      rf_rw     <= RW_READ;
      rf_wsel   <= WSEL_A;
      rf_rsel   <= RSEL_HOLD;
      rf_w      <= '0;
      rd_issued <= 1'b0;
      rd_landed <= 1'b0;
      id_rdata0 <= '0;
      id_rdata1 <= '0;
      id_rvalid <= 1'b0;
    end else begin
      streak <= streak_nxt;
      state  <= id_ack ? RD_WAIT : IDLE;

      if (wb_ack) begin
        rf_rw   <= RW_WRITE;
        rf_wsel <= wb_sel;
        rf_rsel <= RSEL_HOLD;
        rf_w    <= wb_data;
      end else if (id_ack) begin
        rf_rw   <= RW_READ;
        rf_rsel <= id_rsel;
      end else begin
        rf_rw   <= RW_READ;
        rf_rsel <= RSEL_HOLD;
      end

      // Capture is timed by this pipeline rather than by state, so a
      // write granted in RD_WAIT cannot disturb it.
      rd_issued <= id_ack;
      rd_landed <= rd_issued;
      id_rvalid <= rd_landed;
      if (rd_landed) begin
        id_rdata0 <= rf_read0;
        id_rdata1 <= rf_read1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
module tb_regfile_access_ctrl;

  logic       sysclk;
  logic       sysrst_n;
  logic       wb_req;
  logic       wb_sel;
  logic [7:0] wb_data;
  logic       wb_ack;
  logic       id_req;
  logic [1:0] id_rsel;
  logic       id_ack;
  logic [7:0] id_rdata0;
  logic [7:0] id_rdata1;
  logic       id_rvalid;
  logic       rf_rw;
  logic       rf_wsel;
  logic [1:0] rf_rsel;
  logic [7:0] rf_w;
  logic [7:0] rf_read0;
  logic [7:0] rf_read1;

  regfile_access_ctrl #(
    .WIDTH         (8),
    .MAX_WB_STREAK (3)
  ) dut (
    .sysclk    (sysclk),
    .sysrst_n  (sysrst_n),
    .wb_req    (wb_req),
    .wb_sel    (wb_sel),
    .wb_data   (wb_data),
    .wb_ack    (wb_ack),
    .id_req    (id_req),
    .id_rsel   (id_rsel),
    .id_ack    (id_ack),
    .id_rdata0 (id_rdata0),
    .id_rdata1 (id_rdata1),
    .id_rvalid (id_rvalid),
    .rf_rw     (rf_rw),
    .rf_wsel   (rf_wsel),
    .rf_rsel   (rf_rsel),
    .rf_w      (rf_w),
    .rf_read0  (rf_read0),
    .rf_read1  (rf_read1)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int compared   = 0;
  int mismatched = 0;
  int rv_cnt     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register-file model: executes the command registered at the previous edge.
  // Route codes: 00 -> (A,B), 01 -> hold, 10 -> (A,A), 11 -> (B,B).
  logic [7:0] rf_a = '0;
  logic [7:0] rf_b = '0;
  initial begin
    rf_read0 = '0;
    rf_read1 = '0;
  end
  always @(posedge sysclk) begin
    if (rf_rw) begin
      if (rf_wsel) rf_b <= rf_w;
      else         rf_a <= rf_w;
    end else begin
      case (rf_rsel)
        2'b00:   begin rf_read0 <= rf_a; rf_read1 <= rf_b; end
        2'b10:   begin rf_read0 <= rf_a; rf_read1 <= rf_a; end
        2'b11:   begin rf_read0 <= rf_b; rf_read1 <= rf_b; end
        default: ;
      endcase
    end
  end

  // Scoreboard: expected read data is computed from a shadow of accepted
  // writes at grant time and compared when id_rvalid appears.
  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d1;
  } rd_exp_t;
  rd_exp_t    sb_q[$];
  logic [7:0] sh_a  = '0;
  logic [7:0] sh_b  = '0;
  logic [7:0] sh_r0 = '0;
  logic [7:0] sh_r1 = '0;

  always @(negedge sysrst_n) sb_q.delete();

  always @(negedge sysclk) begin
    rd_exp_t e;
    if (sysrst_n) begin
      if (id_rvalid) begin
        rv_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_rvalid", 32'(id_rvalid), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check("rdata0", 32'(id_rdata0), 32'(e.d0));
          check("rdata1", 32'(id_rdata1), 32'(e.d1));
        end
      end
      if (wb_req && wb_ack) begin
        if (wb_sel) sh_b = wb_data;
        else        sh_a = wb_data;
      end
      if (id_req && id_ack) begin
        case (id_rsel)
          2'b00:   begin sh_r0 = sh_a; sh_r1 = sh_b; end
          2'b10:   begin sh_r0 = sh_a; sh_r1 = sh_a; end
          2'b11:   begin sh_r0 = sh_b; sh_r1 = sh_b; end
          default: ;
        endcase
        e.d0 = sh_r0;
        e.d1 = sh_r1;
        sb_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rv_before;
    sysrst_n = 1'b0;
    wb_req   = 1'b0;
    wb_sel   = 1'b0;
    wb_data  = '0;
    id_req   = 1'b0;
    id_rsel  = 2'b00;
    tick();
    tick();
    check("rst_rf_rw",   32'(rf_rw),     32'(0));
    check("rst_rf_rsel", 32'(rf_rsel),   32'(2'b01));
    check("rst_rf_wsel", 32'(rf_wsel),   32'(0));
    check("rst_rf_w",    32'(rf_w),      32'(0));
    check("rst_rdata0",  32'(id_rdata0), 32'(0));
    check("rst_rdata1",  32'(id_rdata1), 32'(0));
    check("rst_rvalid",  32'(id_rvalid), 32'(0));
    sysrst_n = 1'b1;
    tick();
    tick();
    check("idle_rw",   32'(rf_rw),   32'(0));
    check("idle_rsel", 32'(rf_rsel), 32'(2'b01));

    // Back-to-back writes A=11, B=22.
    wb_req = 1'b1; wb_sel = 1'b0; wb_data = 8'h11;
    #1;
    check("wrA_wb_ack", 32'(wb_ack), 32'(1));
    check("wrA_id_ack", 32'(id_ack), 32'(0));
    tick();
    check("wrA_rw",   32'(rf_rw),   32'(1));
    check("wrA_wsel", 32'(rf_wsel), 32'(0));
    check("wrA_w",    32'(rf_w),    32'(8'h11));
    wb_sel = 1'b1; wb_data = 8'h22;
    #1;
    check("wrB_wb_ack", 32'(wb_ack), 32'(1));
    tick();
    wb_req = 1'b0;
    check("wrB_rw",   32'(rf_rw),   32'(1));
    check("wrB_wsel", 32'(rf_wsel), 32'(1));
    check("wrB_w",    32'(rf_w),    32'(8'h22));
    tick();
    check("post_wr_hold_rw",   32'(rf_rw),   32'(0));
    check("post_wr_hold_rsel", 32'(rf_rsel), 32'(2'b01));

    // Read route 00 -> (11,22), with exact latency checks.
    id_req = 1'b1; id_rsel = 2'b00;
    #1;
    check("rd0_id_ack", 32'(id_ack), 32'(1));
    tick();
    id_req = 1'b0;
    check("rd0_rw",   32'(rf_rw),   32'(0));
    check("rd0_rsel", 32'(rf_rsel), 32'(2'b00));
    tick();
    check("rd0_e1_hold",   32'(rf_rsel),   32'(2'b01));
    check("rd0_e1_rvalid", 32'(id_rvalid), 32'(0));
    tick();
    check("rd0_e2_rvalid", 32'(id_rvalid), 32'(1));
    tick();
    check("rd0_pulse_end", 32'(id_rvalid), 32'(0));
    check("rd0_data_held", 32'(id_rdata1), 32'(8'h22));

    // Read route 10 -> (11,11).
    id_req = 1'b1; id_rsel = 2'b10;
    #1;
    check("rd10_id_ack", 32'(id_ack), 32'(1));
    tick();
    id_req = 1'b0;
    tick();
    tick();
    check("rd10_rvalid", 32'(id_rvalid), 32'(1));
    tick();

    // id_req held for 6 cycles: grants alternate.
    rv_before = rv_cnt;
    for (int i = 0; i < 6; i++) begin
      id_req  = 1'b1;
      id_rsel = (i % 4 == 1) ? 2'b11 : 2'(i);
      #1;
      check($sformatf("b2b_id_ack_%0d", i), 32'(id_ack), 32'((i % 2) == 0));
      tick();
    end
    id_req = 1'b0;
    tick();
    tick();
    tick();
    check("b2b_rvalid_count", 32'(rv_cnt - rv_before), 32'(3));

    // Single write B=5A, then asynchronous reset mid-cycle.
    wb_req = 1'b1; wb_sel = 1'b1; wb_data = 8'h5A;
    #1;
    check("wr5A_wb_ack", 32'(wb_ack), 32'(1));
    tick();
    wb_req = 1'b0;
    check("wr5A_rw",   32'(rf_rw),   32'(1));
    check("wr5A_wsel", 32'(rf_wsel), 32'(1));
    check("wr5A_w",    32'(rf_w),    32'(8'h5A));
    #2;
    sysrst_n = 1'b0;
    #1;
    check("async_rst_rw",     32'(rf_rw),     32'(0));
    check("async_rst_rsel",   32'(rf_rsel),   32'(2'b01));
    check("async_rst_w",      32'(rf_w),      32'(0));
    check("async_rst_rdata0", 32'(id_rdata0), 32'(0));
    check("async_rst_rvalid", 32'(id_rvalid), 32'(0));
    tick();
    sysrst_n = 1'b1;
    tick();

    // Starvation bound: both requests held, pattern wb,wb,wb,id repeating.
    for (int i = 0; i < 12; i++) begin
      wb_req  = 1'b1;
      wb_sel  = i[0];
      wb_data = 8'h30 + 8'(i);
      id_req  = 1'b1;
      id_rsel = 2'b00;
      #1;
      check($sformatf("stv_id_ack_%0d", i), 32'(id_ack), 32'((i % 4) == 3));
      check($sformatf("stv_wb_ack_%0d", i), 32'(wb_ack), 32'((i % 4) != 3));
      tick();
    end
    wb_req = 1'b0;
    id_req = 1'b0;
    tick();
    tick();
    tick();

    // Reset while a read is in flight: the read is dropped.
    id_req = 1'b1; id_rsel = 2'b00;
    #1;
    check("rdrst_id_ack", 32'(id_ack), 32'(1));
    tick();
    id_req = 1'b0;
    tick();
    sysrst_n = 1'b0;
    #1;
    check("rdrst_rvalid", 32'(id_rvalid), 32'(0));
    tick();
    sysrst_n = 1'b1;
    rv_before = rv_cnt;
    tick();
    tick();
    tick();
    tick();
    check("rdrst_no_rvalid", 32'(rv_cnt - rv_before), 32'(0));
    id_req = 1'b1; id_rsel = 2'b00;
    #1;
    check("rdrst_regrant", 32'(id_ack), 32'(1));
    tick();
    id_req = 1'b0;
    tick();
    tick();
    check("rdrst_regrant_rvalid", 32'(id_rvalid), 32'(1));
    tick();
    tick();
    check("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Sequencer and arbiter in front of the two-entry 8-bit register file (single rw command port, A/B write select, 2-bit read-route select).
- Shares that port between two requesters: the ID-stage operand read port and the WB-stage result write port.
- WB has priority, with a bounded streak so ID reads cannot starve.
- Drives a safe "hold" command whenever idle, tracks the two-cycle read latency, and returns captured read data with a valid pulse.

Parameters:
- WIDTH, 8, data width of the register-file write/read buses.
- MAX_WB_STREAK, 3, maximum consecutive WB grants while an ID read is pending; must be at least 1.

Ports:
- sysclk  in  1  single clock; all state updates on its rising edge.
- sysrst_n  in  1  asynchronous active-low reset.
- wb_req  in  1  WB write request.
- wb_sel  in  1  write target: 0=A, 1=B.
- wb_data  in  WIDTH  write data.
- wb_ack  out  1  combinational; wb_req&wb_ack at an edge means the write is accepted.
- id_req  in  1  ID read request.
- id_rsel  in  2  read-route code, passed opaquely to the register file.
- id_ack  out  1  combinational; id_req&id_ack at an edge means the read is accepted.
- id_rdata0  out  WIDTH  captured register-file read0.
- id_rdata1  out  WIDTH  captured register-file read1.
- id_rvalid  out  1  one-cycle pulse when id_rdata0/1 are updated.
- rf_rw  out  1  register-file command: 0=read, 1=write (registered).
- rf_wsel  out  1  register-file write select (registered).
- rf_rsel  out  2  register-file read select (registered).
- rf_w  out  WIDTH  register-file write data (registered).
- rf_read0  in  WIDTH  register-file read0.
- rf_read1  in  WIDTH  register-file read1.

Behaviour:
- Reset (async, sysrst_n=0):
  - rf_rw=0, rf_rsel=RSEL_HOLD (2'b01), rf_wsel=0, rf_w=0.
  - id_rdata0/1=0, id_rvalid=0, state=IDLE, streak=0.
- Hold command: rf_rw=0 with rf_rsel=2'b01 leaves read0/read1 unchanged. It is driven in every cycle with no grant; the command port is never left at a mutating read when idle.
- States: IDLE, RD_WAIT. The write path needs no state.
- Grant logic, evaluated combinationally each cycle:
  - id_ok = id_req & (state==IDLE).
  - read_wins = id_ok & (~wb_req | streak==MAX_WB_STREAK).
  - id_ack = read_wins; wb_ack = wb_req & ~read_wins.
  - At most one ack per cycle.
- Write grant at edge E:
  - rf_rw<=1, rf_wsel<=wb_sel, rf_w<=wb_data.
  - Register file writes at E+1.
  - Back-to-back writes allowed every cycle.
- Read grant at edge E0:
  - rf_rw<=0, rf_rsel<=id_rsel, state<=RD_WAIT.
  - The register file updates read0/read1 at E1, when the command returns to hold (or a write).
  - State returns to IDLE at E1.
  - At E2: id_rdata0<=rf_read0, id_rdata1<=rf_read1, id_rvalid<=1 for one cycle.
  - Capture is driven by a one-bit pending pipeline, independent of state.
- Read throughput is one per 2 cycles; id_ack=0 throughout RD_WAIT.
- Writes may be granted during RD_WAIT (issued at E1, written at E2). This does not disturb read0/read1.
- Streak counter:
  - +1 on each wb grant while id_req=1.
  - Cleared on an id grant, or in any cycle with id_req=0.
  - Saturates at MAX_WB_STREAK.
- Simultaneous wb_req and id_req in IDLE with streak<MAX: WB wins. At streak==MAX: ID wins and the streak clears.
- No grant → hold command registered; outputs not otherwise changed.
- Reset mid-read: the outstanding read is dropped, no id_rvalid is produced, and all outputs go to reset values immediately.
- id_rdata0/1 hold their value between id_rvalid pulses.

Decomposition:
- Package rf_ctrl_pkg:
  - RW_READ=1'b0, RW_WRITE=1'b1.
  - RSEL_HOLD=2'b01.
  - State encoding IDLE/RD_WAIT.
  - WSEL_A=1'b0, WSEL_B=1'b1.
- One natural sub-module: rf_grant_logic. It is combinational (id_ack/wb_ack, streak next-value) and is instantiated once. Command registers, the read-pending pipeline and capture stay in the top.

Test Plan:
- Reset: assert sysrst_n=0 mid-cycle → rf_rw=0, rf_rsel=01, id_rvalid=0, id_rdata0/1=0 immediately; hold persists with no requests.
- Single write: wb_req=1, wb_sel=1, wb_data=8'h5A for one cycle → wb_ack=1 that cycle; next cycle rf_rw=1, rf_wsel=1, rf_w=5A; following cycle hold.
- Single read: with regfile read0=8'h11, read1=8'h22, issue id_req with id_rsel=2'b10 → id_ack=1 at E0; id_rvalid=1 exactly in the cycle after E2, with id_rdata0=11, id_rdata1=11.
- Back-to-back reads: id_req held high for 6 cycles → id_ack pattern 1,0,1,0,1,0; three id_rvalid pulses, each 2 cycles after its grant.
- Starvation bound: wb_req and id_req both held high, MAX_WB_STREAK=3 → wb_ack for 3 cycles, then id_ack, then wb_ack resumes (including during RD_WAIT); pattern repeats.
- Reset during read: grant a read, deassert sysrst_n at E1 → no id_rvalid after release; the first subsequent id_req is granted from IDLE.
